// File: rtl/ula8_sequenciador.sv
// ula8_sequenciador: sequences a W-bit ALU operation (W = 4*NIBBLES) through one external
// 4-bit ula_74181 slice, one nibble per clock, LSB first, chaining the slice carry between nibbles.
// One operation is in flight at a time. The FSM runs IDLE -> EXEC (NIBBLES cycles) -> DONE -> IDLE.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_a, req_b [W]              operands
//   req_s [4], req_m, req_c_in    function select, mode, active-low carry into nibble 0
//   ula_a, ula_b, ula_s, ula_m,
//   ula_c_in                      drive to the shared ula_74181 slice
//   ula_f, ula_a_eq_b, ula_c_out  combinational results back from the slice
//   rsp_valid/rsp_ready           response handshake
//   rsp_f [W], rsp_c_out,
//   rsp_a_eq_b                    assembled result, last-nibble carry, AND of nibble A=B flags
//   busy                          high in EXEC or DONE
//   ops_done [16]                 completed-response counter, saturating (only with ULA8_SEQ_CNT_EN)
//
// Build option: define ULA8_SEQ_CNT_EN to add the ops_done output and its counter.
module ula8_sequenciador #(
   parameter int unsigned NIBBLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [4*NIBBLES-1:0]   req_a,
   input  logic [4*NIBBLES-1:0]   req_b,
   input  logic [3:0]             req_s,
   input  logic                   req_m,
   input  logic                   req_c_in,
   output logic [3:0]             ula_a,
   output logic [3:0]             ula_b,
   output logic [3:0]             ula_s,
   output logic                   ula_m,
   output logic                   ula_c_in,
   input  logic [3:0]             ula_f,
   input  logic                   ula_a_eq_b,
   input  logic                   ula_c_out,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [4*NIBBLES-1:0]   rsp_f,
   output logic                   rsp_c_out,
   output logic                   rsp_a_eq_b,
   output logic                   busy
`ifdef ULA8_SEQ_CNT_EN
   ,
   output logic [15:0]            ops_done
`endif
);

   localparam int unsigned W    = 4 * NIBBLES;
   localparam int unsigned NibW = $clog2(NIBBLES) + 1;

   typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

   state_e          state_q, state_d;
   logic [NibW-1:0] nib_q, nib_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    rsp_f_q, rsp_f_d;
   logic [3:0]      s_q, s_d;
   logic            m_q, m_d;
   logic            cin_q, cin_d;
   logic            carry_q, carry_d;
   logic            acc_eq_q, acc_eq_d;

   logic            last_nib;
   logic            rsp_fire;

   assign last_nib = (nib_q == NibW'(NIBBLES - 1));
   assign rsp_fire = rsp_valid & rsp_ready;

   always_comb begin
      state_d   = state_q;
      nib_d     = nib_q;
      a_d       = a_q;
      b_d       = b_q;
      rsp_f_d   = rsp_f_q;
      s_d       = s_q;
      m_d       = m_q;
      cin_d     = cin_q;
      carry_d   = carry_q;
      acc_eq_d  = acc_eq_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b0;
      ula_a     = 4'h0;
      ula_b     = 4'h0;
      ula_c_in  = 1'b1;

      unique case (state_q)
         StIdle: begin
            req_ready = 1'b1;
            if (req_valid) begin
               a_d      = req_a;
               b_d      = req_b;
               s_d      = req_s;
               m_d      = req_m;
               cin_d    = req_c_in;
               nib_d    = '0;
               acc_eq_d = 1'b1;
               state_d  = StExec;
            end
         end
         StExec: begin
            busy     = 1'b1;
            // Operands shift right each cycle, so the live nibble is always at [3:0].
            ula_a    = a_q[3:0];
            ula_b    = b_q[3:0];
            ula_c_in = (nib_q == '0) ? cin_q : carry_q;
            for (int i = 0; i < NIBBLES; i++) begin
               if (nib_q == NibW'(i)) begin
                  rsp_f_d[4*i +: 4] = ula_f;
               end
            end
            a_d      = a_q >> 4;
            b_d      = b_q >> 4;
            carry_d  = ula_c_out;
            acc_eq_d = acc_eq_q & ula_a_eq_b;
            // Counter is one bit wider than needed, so this never wraps past the last nibble.
            nib_d    = nib_q + 1'b1;
            if (last_nib) begin
               state_d = StDone;
            end
         end
         StDone: begin
            busy      = 1'b1;
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // s and m hold their last latched values outside EXEC.
   assign ula_s      = s_q;
   assign ula_m      = m_q;
   assign rsp_f      = rsp_f_q;
   assign rsp_c_out  = carry_q;
   assign rsp_a_eq_b = acc_eq_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         nib_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         rsp_f_q  <= '0;
         s_q      <= 4'h0;
         m_q      <= 1'b0;
         cin_q    <= 1'b1;
         carry_q  <= 1'b0;
         acc_eq_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         nib_q    <= nib_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rsp_f_q  <= rsp_f_d;
         s_q      <= s_d;
         m_q      <= m_d;
         cin_q    <= cin_d;
         carry_q  <= carry_d;
         acc_eq_q <= acc_eq_d;
      end
   end

`ifdef ULA8_SEQ_CNT_EN
   logic [15:0] ops_q, ops_d;

   always_comb begin
      ops_d = ops_q;
      if (rsp_fire && (ops_q != 16'hFFFF)) begin
         ops_d = ops_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ops_q <= 16'h0000;
      end else begin
         ops_q <= ops_d;
      end
   end

   assign ops_done = ops_q;
`else
   // Completion counter not built; rsp_fire only feeds it.
   logic unused_rsp_fire;
   assign unused_rsp_fire = rsp_fire;
`endif

endmodule

// File: tb/tb_ula8_sequenciador.sv
// Self-checking bench for ula8_sequenciador (NIBBLES=2) with a behavioural ula_74181 slice model
// (active-high data, active-low carry, A=B high when F=1111). Directed vector table plus
// hand-written sequences for backpressure, reset mid-operation and the optional op counter.
module tb_ula8_sequenciador;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_a;
   logic [7:0] req_b;
   logic [3:0] req_s;
   logic       req_m;
   logic       req_c_in;
   logic [3:0] ula_a;
   logic [3:0] ula_b;
   logic [3:0] ula_s;
   logic       ula_m;
   logic       ula_c_in;
   logic [3:0] ula_f;
   logic       ula_a_eq_b;
   logic       ula_c_out;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_f;
   logic       rsp_c_out;
   logic       rsp_a_eq_b;
   logic       busy;
`ifdef ULA8_SEQ_CNT_EN
   logic [15:0] ops_done;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ula8_sequenciador #(.NIBBLES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_s      (req_s),
      .req_m      (req_m),
      .req_c_in   (req_c_in),
      .ula_a      (ula_a),
      .ula_b      (ula_b),
      .ula_s      (ula_s),
      .ula_m      (ula_m),
      .ula_c_in   (ula_c_in),
      .ula_f      (ula_f),
      .ula_a_eq_b (ula_a_eq_b),
      .ula_c_out  (ula_c_out),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_f      (rsp_f),
      .rsp_c_out  (rsp_c_out),
      .rsp_a_eq_b (rsp_a_eq_b),
      .busy       (busy)
`ifdef ULA8_SEQ_CNT_EN
      ,
      .ops_done   (ops_done)
`endif
   );

   // 74181 slice: X/Y are the internal propagate/generate terms in active-high form.
   logic [3:0] mx, my;
   logic [4:0] msum;
   always_comb begin
      mx         = ula_a | (ula_b & {4{ula_s[0]}}) | (~ula_b & {4{ula_s[1]}});
      my         = (ula_a & ~ula_b & {4{ula_s[2]}}) | (ula_a & ula_b & {4{ula_s[3]}});
      msum       = {1'b0, mx} + {1'b0, my} + {4'b0000, ~ula_c_in};
      ula_f      = ula_m ? ~(mx ^ my) : msum[3:0];
      ula_c_out  = ~msum[4];
      ula_a_eq_b = (ula_f == 4'hF);
   end

   typedef struct {
      logic       m;
      logic [3:0] s;
      logic       cin;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] f;
      logic       c;
      logic       eq;
      logic       chk_c;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Presents one request from IDLE and walks it to DONE, checking the slice drive on the way.
   task automatic issue(input vec_t v);
      @(negedge clk);
      chk("req_ready_idle", {31'b0, req_ready}, 1);
      req_valid = 1'b1;
      req_a     = v.a;
      req_b     = v.b;
      req_s     = v.s;
      req_m     = v.m;
      req_c_in  = v.cin;
      @(negedge clk);
      req_valid = 1'b0;
      chk("busy_exec", {31'b0, busy}, 1);
      chk("req_ready_exec", {31'b0, req_ready}, 0);
      chk("ula_a_nib0", {28'b0, ula_a}, {28'b0, v.a[3:0]});
      chk("ula_b_nib0", {28'b0, ula_b}, {28'b0, v.b[3:0]});
      chk("ula_s_exec", {28'b0, ula_s}, {28'b0, v.s});
      chk("ula_m_exec", {31'b0, ula_m}, {31'b0, v.m});
      chk("ula_c_in_nib0", {31'b0, ula_c_in}, {31'b0, v.cin});
      chk("rsp_valid_exec0", {31'b0, rsp_valid}, 0);
      @(negedge clk);
      chk("ula_a_nib1", {28'b0, ula_a}, {28'b0, v.a[7:4]});
      chk("ula_b_nib1", {28'b0, ula_b}, {28'b0, v.b[7:4]});
      chk("rsp_valid_exec1", {31'b0, rsp_valid}, 0);
      @(negedge clk);
      chk("rsp_valid_done", {31'b0, rsp_valid}, 1);
      chk("rsp_f", {24'b0, rsp_f}, {24'b0, v.f});
      chk("rsp_a_eq_b", {31'b0, rsp_a_eq_b}, {31'b0, v.eq});
      if (v.chk_c) chk("rsp_c_out", {31'b0, rsp_c_out}, {31'b0, v.c});
      chk("ula_a_done", {28'b0, ula_a}, 0);
      chk("ula_c_in_done", {31'b0, ula_c_in}, 1);
      chk("ula_s_held", {28'b0, ula_s}, {28'b0, v.s});
      chk("req_ready_done", {31'b0, req_ready}, 0);
   endtask

   task automatic take_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_valid_after_hs", {31'b0, rsp_valid}, 0);
      chk("req_ready_after_hs", {31'b0, req_ready}, 1);
      chk("busy_after_hs", {31'b0, busy}, 0);
   endtask

   initial begin
      //          m     s        cin   a      b      f      c     eq    chk_c
      vecs[0] = '{1'b1, 4'b1011, 1'b1, 8'hC5, 8'h3F, 8'h05, 1'b0, 1'b0, 1'b0}; // A and B
      vecs[1] = '{1'b0, 4'b1001, 1'b1, 8'h0F, 8'h01, 8'h10, 1'b1, 1'b0, 1'b1}; // A plus B
      vecs[2] = '{1'b0, 4'b1001, 1'b1, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1}; // carry out
      vecs[3] = '{1'b0, 4'b0110, 1'b1, 8'h5A, 8'h5A, 8'hFF, 1'b1, 1'b1, 1'b1}; // A-B-1, equal
      vecs[4] = '{1'b0, 4'b0110, 1'b1, 8'h5A, 8'h5B, 8'hFE, 1'b1, 1'b0, 1'b1}; // A-B-1, unequal
      vecs[5] = '{1'b1, 4'b0000, 1'b1, 8'hA5, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0}; // not A
      vecs[6] = '{1'b0, 4'b1001, 1'b0, 8'h12, 8'h34, 8'h47, 1'b1, 1'b0, 1'b1}; // A+B+1
      vecs[7] = '{1'b1, 4'b0110, 1'b1, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b1, 1'b0}; // xor, all ones
      vecs[8] = '{1'b0, 4'b0110, 1'b0, 8'h37, 8'h12, 8'h25, 1'b0, 1'b0, 1'b1}; // A minus B
      vecs[9] = '{1'b0, 4'b0000, 1'b1, 8'h9C, 8'h00, 8'h9C, 1'b1, 1'b0, 1'b1}; // pass A

      rst       = 1'b1;
      req_valid = 1'b0;
      req_a     = 8'h00;
      req_b     = 8'h00;
      req_s     = 4'h0;
      req_m     = 1'b0;
      req_c_in  = 1'b1;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst_req_ready", {31'b0, req_ready}, 1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_rsp_f", {24'b0, rsp_f}, 0);
      chk("rst_rsp_c_out", {31'b0, rsp_c_out}, 0);
      chk("rst_rsp_a_eq_b", {31'b0, rsp_a_eq_b}, 0);
      chk("rst_ula_a", {28'b0, ula_a}, 0);
      chk("rst_ula_s", {28'b0, ula_s}, 0);
      chk("rst_ula_m", {31'b0, ula_m}, 0);
      chk("rst_ula_c_in", {31'b0, ula_c_in}, 1);

      for (int i = 0; i < 10; i++) begin
         issue(vecs[i]);
         take_rsp();
      end

      // Backpressure: response held, stray request ignored and not queued.
      issue(vecs[0]);
      for (int k = 0; k < 5; k++) begin
         req_valid = 1'b1;
         req_a     = 8'h11;
         req_b     = 8'h22;
         req_s     = 4'b1001;
         req_m     = 1'b0;
         @(negedge clk);
         chk("bp_rsp_valid", {31'b0, rsp_valid}, 1);
         chk("bp_rsp_f", {24'b0, rsp_f}, 32'h05);
         chk("bp_req_ready", {31'b0, req_ready}, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("bp_no_accept_on_hs", {31'b0, busy}, 0);
      chk("bp_req_ready_after", {31'b0, req_ready}, 1);
      chk("bp_rsp_valid_after", {31'b0, rsp_valid}, 0);
      req_valid = 1'b0;
      @(negedge clk);
      chk("bp_not_queued", {31'b0, busy}, 0);

      // Reset after the first nibble has been processed.
      req_valid = 1'b1;
      req_a     = 8'h0F;
      req_b     = 8'h01;
      req_s     = 4'b1001;
      req_m     = 1'b0;
      req_c_in  = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("mid_ula_c_in_chained", {31'b0, ula_c_in}, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_req_ready", {31'b0, req_ready}, 1);
      chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 0);
      chk("mid_rst_ula_c_in", {31'b0, ula_c_in}, 1);
      chk("mid_rst_busy", {31'b0, busy}, 0);
      chk("mid_rst_rsp_f", {24'b0, rsp_f}, 0);
      issue(vecs[5]);
      take_rsp();

`ifdef ULA8_SEQ_CNT_EN
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("cnt_rst", {16'b0, ops_done}, 0);
      for (int i = 0; i < 3; i++) begin
         issue(vecs[i]);
         take_rsp();
      end
      chk("cnt_three", {16'b0, ops_done}, 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("cnt_rst_again", {16'b0, ops_done}, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
